ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit; consumer side of the PC register.
- Reads the current pc and issues one read per instruction on a valid/ready instruction-memory port.
- Returns the fetched word to decode on a valid/ready port.
- Pulses pc_wen back to the PC register only when decode accepts the instruction, so pc advances exactly once per retired fetch.

Parameters:
- ADDR_W, 32, address width of pc and imem_req_addr
- DATA_W, 32, instruction width
- TIMEOUT_CYC, 255, response watchdog limit in cycles (used only with IFU_TIMEOUT_EN)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- pc  input  ADDR_W  current fetch address from the PC register
- flush  input  1  redirect: abandon the current fetch; pc is already redirected
- pc_wen  output  1  one-cycle pulse: PC register loads dnpc
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDR_W  read address
- imem_rsp_valid  input  1  read data valid
- imem_rsp_ready  output  1  IFU accepts response
- imem_rsp_data  input  DATA_W  read data
- imem_rsp_err  input  1  bus error with response
- inst_valid  output  1  instruction valid to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  DATA_W  instruction word
- inst_pc  output  ADDR_W  address of inst
- inst_fault  output  1  fetch fault (misaligned, bus error, timeout)

Behaviour:
- FSM states: BOOT, REQ, WAIT, DRAIN, OUT.
- Reset (rst=0, async): state=BOOT. All outputs 0; inst, inst_pc, inst_fault registers cleared.
- BOOT: one cycle, all outputs 0, then REQ. Gives the PC register time to leave its own reset.
- REQ:
  - imem_req_valid=1; imem_req_addr=pc (combinational). pc is stable because pc_wen=0 outside OUT.
  - On handshake (valid & ready): latch inst_pc<=pc. Go to WAIT, or to DRAIN if flush=1 in the same cycle.
  - Misaligned pc (pc[1:0]!=0): no request is issued; imem_req_valid=0. Next state OUT with inst=0, inst_pc=pc, inst_fault=1.
  - flush with no handshake: stay in REQ. The address follows the redirected pc.
- WAIT:
  - imem_rsp_ready=1.
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_fault<=imem_rsp_err, go to OUT.
  - flush while in WAIT: go to DRAIN. If rsp_valid arrives in the same cycle, the response is consumed and dropped, and the next state is REQ.
- DRAIN:
  - imem_rsp_ready=1.
  - The first response is consumed and discarded, then go to REQ.
  - flush in DRAIN has no extra effect.
- OUT:
  - inst_valid=1. inst, inst_pc and inst_fault are held stable until the handshake.
  - On inst_ready and no flush: pc_wen=1 for that cycle (combinational), then go to REQ. The next REQ sees the updated pc.
  - On flush: inst_valid drops next cycle, pc_wen=0 (flush beats inst_ready), go to REQ.
- Protocol rules:
  - At most one outstanding request.
  - imem_req_valid is never deasserted before its handshake, except on a misalignment detected at REQ entry.
  - pc_wen is asserted only in OUT, at most once per instruction.
- Throughput: minimum 3 cycles per instruction (REQ, WAIT, OUT) with a zero-wait memory and inst_ready tied high.
- Reset asserted mid-fetch: the FSM returns to BOOT immediately. The memory must be reset in the same domain; no stale response tracking.

Optional Feature:
- Macro: IFU_TIMEOUT_EN.
- When defined:
  - An 8-bit-minimum counter (width clog2(TIMEOUT_CYC+1)) clears on entry to WAIT or DRAIN and increments each cycle without rsp_valid.
  - At TIMEOUT_CYC, WAIT goes to OUT with inst=0 and inst_fault=1; DRAIN goes to REQ.
- When undefined: no counter; WAIT and DRAIN wait indefinitely.

Test Plan:
- Zero-wait memory, inst_ready=1, pc=0x8000_0000 advancing +4 on pc_wen → imem_req_addr sequence 0x8000_0000, 0x8000_0004, ...; one pc_wen per 3 cycles; inst_pc matches each address.
- rsp_valid delayed 5 cycles, inst_ready low 4 cycles in OUT → inst and inst_pc held constant; no pc_wen until the inst_ready cycle; exactly one pc_wen.
- flush during WAIT, response 0xDEADBEEF arrives 2 cycles later → response dropped, inst_valid never asserted for it, next request uses the redirected pc=0x8000_0100, pc_wen=0 throughout.
- pc=0x8000_0002 → no imem_req_valid; inst_valid=1, inst_fault=1, inst=0, inst_pc=0x8000_0002.
- imem_rsp_err=1 with data 0x12345678 → inst_fault=1, inst=0x12345678; pc_wen on accept.
- rst pulled low in WAIT → all outputs 0 asynchronously; after release, BOOT for 1 cycle, then REQ. With IFU_TIMEOUT_EN and TIMEOUT_CYC=4 and no response → inst_fault=1 after 4 WAIT cycles.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: reads pc, issues one imem read per instruction, hands it to decode.
// Optional response watchdog is enabled by defining IFU_TIMEOUT_EN.
module ifu_fetch #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_wen,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] inst_nxt;
  logic [ADDR_W-1:0] inst_pc_nxt;
  logic              inst_fault_nxt;
  logic              misaligned;
  logic              expired;

  assign misaligned = (pc[1:0] != 2'b00);

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Fires on the cycle that would bring the silent-cycle count up to the limit.
  assign expired = ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC)) && !imem_rsp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end
`else
  logic unused_timeout;

  assign expired        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Handshake-facing outputs decode straight from the state register.
  assign imem_req_valid = (state == S_REQ) && !misaligned;
  assign imem_req_addr  = (state == S_REQ) ? pc : '0;
  assign imem_rsp_ready = (state == S_WAIT) || (state == S_DRAIN);
  assign inst_valid     = (state == S_OUT);
  assign pc_wen         = (state == S_OUT) && inst_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_BOOT;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_fault <= inst_fault_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    inst_fault_nxt = inst_fault;
`ifdef IFU_TIMEOUT_EN
    cnt_nxt        = '0;
`endif
    case (state)
      S_BOOT: state_nxt = S_REQ;

      S_REQ: begin
        if (flush) begin
          // A request already accepted must still have its response drained.
          if (imem_req_valid && imem_req_ready) begin
            inst_pc_nxt = pc;
            state_nxt   = S_DRAIN;
          end
        end else if (misaligned) begin
          inst_nxt       = '0;
          inst_pc_nxt    = pc;
          inst_fault_nxt = 1'b1;
          state_nxt      = S_OUT;
        end else if (imem_req_ready) begin
          inst_pc_nxt = pc;
          state_nxt   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush) begin
          state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          inst_nxt       = imem_rsp_data;
          inst_fault_nxt = imem_rsp_err;
          state_nxt      = S_OUT;
        end else if (expired) begin
          inst_nxt       = '0;
          inst_fault_nxt = 1'b1;
          state_nxt      = S_OUT;
        end else begin
`ifdef IFU_TIMEOUT_EN
          cnt_nxt = cnt + CNT_W'(1);
`endif
        end
      end

      S_DRAIN: begin
        if (imem_rsp_valid || expired) begin
          state_nxt = S_REQ;
        end else begin
`ifdef IFU_TIMEOUT_EN
          cnt_nxt = cnt + CNT_W'(1);
`endif
        end
      end

      S_OUT: begin
        if (flush || inst_ready) state_nxt = S_REQ;
      end

      default: state_nxt = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: bench-side PC register and imem model, scoreboard of expected instructions.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        pc_wen;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_wen(pc_wen),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  exp_t        sb[$];

  // Memory-model knobs consumed by the next accepted request.
  int unsigned rsp_delay = 0;
  bit          ovr_en = 0;
  logic [31:0] data_ovr = '0;
  bit          err_next = 0;
  bit          no_rsp = 0;

  bit          outst = 0;
  int unsigned mcnt = 0;
  logic [31:0] mdata = '0;
  logic        merr = 1'b0;
  bit          mnorsp = 0;

  bit          s_req_valid, s_req_hs, s_rsp_hs, s_acc, s_wen, s_inst_valid, s_rsp_ready, s_fault;
  logic [31:0] s_req_addr, s_inst, s_inst_pc;
  int          cyc = 0;
  int          n_wen = 0;
  int          n_acc = 0;
  int          n_req = 0;
  bit          held = 0;
  logic [31:0] h_inst, h_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // One clock: drive memory response, sample at negedge, score, advance models after posedge.
  task automatic tick();
    exp_t e;
    imem_rsp_valid = outst && !mnorsp && (mcnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mdata : 32'h0;
    imem_rsp_err   = imem_rsp_valid ? merr : 1'b0;
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_req_hs     = imem_req_valid && imem_req_ready;
    s_rsp_hs     = imem_rsp_valid && imem_rsp_ready;
    s_acc        = inst_valid && inst_ready && !flush;
    s_wen        = pc_wen;
    s_inst_valid = inst_valid;
    s_rsp_ready  = imem_rsp_ready;
    s_inst       = inst;
    s_inst_pc    = inst_pc;
    s_fault      = inst_fault;
    if (s_req_hs) begin
      chk("req_addr", imem_req_addr, pc);
      chk("req_aligned", 32'(pc[1:0]), 32'h0);
      chk("one_outstanding", 32'(outst), 32'h0);
      e.pc    = pc;
      e.inst  = no_rsp ? 32'h0 : (ovr_en ? data_ovr : word_at(pc));
      e.fault = no_rsp ? 1'b1 : err_next;
      sb.push_back(e);
    end
    if (inst_valid) begin
      chk("inst_pending", 32'(sb.size() > 0), 32'h1);
      if (held) begin
        chk("hold_inst", inst, h_inst);
        chk("hold_inst_pc", inst_pc, h_pc);
      end
    end
    if (inst_valid || pc_wen) chk("pc_wen", 32'(pc_wen), 32'(s_acc));
    if (s_acc && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_inst", inst, e.inst);
      chk("sb_inst_pc", inst_pc, e.pc);
      chk("sb_fault", 32'(inst_fault), 32'(e.fault));
    end
    held   = inst_valid && !s_acc && !flush;
    h_inst = inst;
    h_pc   = inst_pc;
    if (flush && !s_acc && sb.size() > 0) e = sb.pop_front();
    @(posedge clk);
    #1;
    cyc++;
    if (s_wen) begin
      pc = pc + 32'd4;
      n_wen++;
    end
    if (s_acc) n_acc++;
    if (s_rsp_hs) outst = 0;
    else if (outst && mcnt > 0) mcnt--;
    if (s_req_hs) begin
      n_req++;
      outst    = 1;
      mcnt     = rsp_delay;
      mdata    = ovr_en ? data_ovr : word_at(s_req_addr);
      merr     = err_next;
      mnorsp   = no_rsp;
      ovr_en   = 0;
      err_next = 0;
    end
    flush = 1'b0;
  endtask

  task automatic accept_one(input int budget, output int c);
    int a0 = n_acc;
    for (int k = 0; k < budget && n_acc == a0; k++) tick();
    chk("accept_budget", 32'(n_acc - a0), 32'h1);
    c = cyc;
  endtask

  task automatic wait_req_hs(input int budget);
    bit got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      tick();
      got = s_req_hs;
    end
    chk("req_budget", 32'(got), 32'h1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_rsp_ready"}, 32'(imem_rsp_ready), 32'h0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_pc_wen"}, 32'(pc_wen), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_inst_fault"}, 32'(inst_fault), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, last, w0, r0, nw;
    bit found;
    rst = 1'b0; pc = 32'h8000_0000; flush = 1'b0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Back-to-back fetch, zero-wait memory.
    last = 0;
    for (int i = 0; i < 4; i++) begin
      accept_one(20, c);
      chk("tp_inst_pc", s_inst_pc, 32'h8000_0000 + 32'(4 * i));
      if (i > 0) chk("tp_interval", 32'(c - last), 32'd3);
      last = c;
    end
    chk("tp_wen_count", 32'(n_wen), 32'd4);

    // Slow memory and stalled decode.
    w0 = n_wen; rsp_delay = 5; inst_ready = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      found = s_inst_valid;
    end
    chk("stall_inst_valid", 32'(found), 32'h1);
    repeat (3) tick();
    chk("stall_no_wen", 32'(n_wen - w0), 32'h0);
    inst_ready = 1'b1;
    tick();
    chk("stall_accept", 32'(s_acc), 32'h1);
    chk("stall_inst_pc", s_inst_pc, 32'h8000_0010);
    chk("stall_one_wen", 32'(n_wen - w0), 32'h1);
    rsp_delay = 0;

    // Flush while waiting: stale response must vanish.
    w0 = n_wen; rsp_delay = 2; ovr_en = 1; data_ovr = 32'hDEAD_BEEF;
    wait_req_hs(10);
    pc = 32'h8000_0100; flush = 1'b1;
    tick();
    chk("flush_sb_empty", 32'(sb.size()), 32'h0);
    rsp_delay = 0;
    wait_req_hs(20);
    chk("flush_redirect_addr", s_req_addr, 32'h8000_0100);
    chk("flush_no_wen", 32'(n_wen - w0), 32'h0);
    accept_one(10, c);
    chk("flush_next_inst", s_inst, word_at(32'h8000_0100));

    // Misaligned pc faults without touching memory.
    r0 = n_req; pc = 32'h8000_0002;
    sb.push_back('{inst: 32'h0, pc: 32'h8000_0002, fault: 1'b1});
    accept_one(10, c);
    chk("mis_no_req", 32'(n_req - r0), 32'h0);
    chk("mis_inst_pc", s_inst_pc, 32'h8000_0002);
    chk("mis_fault", 32'(s_fault), 32'h1);
    chk("mis_inst", s_inst, 32'h0);
    pc = 32'h8000_0200;

    // Bus error propagates with its data.
    w0 = n_wen; ovr_en = 1; data_ovr = 32'h1234_5678; err_next = 1;
    accept_one(10, c);
    chk("err_inst", s_inst, 32'h1234_5678);
    chk("err_fault", 32'(s_fault), 32'h1);
    chk("err_wen", 32'(n_wen - w0), 32'h1);

    // Asynchronous reset in the middle of a fetch.
    rsp_delay = 10;
    wait_req_hs(10);
    chk("wait_rsp_ready", 32'(imem_rsp_ready), 32'h1);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb.delete(); outst = 0; held = 0; rsp_delay = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("boot_req_valid", 32'(s_req_valid), 32'h0);
    tick();
    chk("req_after_boot", 32'(s_req_valid), 32'h1);
    accept_one(10, c);
    chk("post_rst_inst_pc", s_inst_pc, 32'h8000_0204);

`ifdef IFU_TIMEOUT_EN
    // Memory never answers: watchdog faults after four silent WAIT cycles.
    no_rsp = 1;
    wait_req_hs(10);
    no_rsp = 0;
    nw = 0; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (s_inst_valid) found = 1;
      else if (s_rsp_ready) nw++;
    end
    chk("to_wait_cycles", 32'(nw), 32'd4);
    chk("to_fault", 32'(s_fault), 32'h1);
    outst = 0;
`else
    nw = 0;
`endif

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
